// File: rtl/uart_ip_if.sv
// Parallel and serial signals of the uart_ip block, named from the USB host's viewpoint.
// The bridge uses the slave modport; the fabric/host side uses the master modport.
interface uart_ip_if;
    logic       RX;
    logic       TX;
    logic       RTS;
    logic       CTS;
    logic [7:0] TxD_par;
    logic       TxD_ready;
    logic [7:0] RxD_par;
    logic       RxD_start;

    modport master (output RX, RTS, RxD_par, RxD_start,
                    input  TX, CTS, TxD_par, TxD_ready);
    modport slave  (input  RX, RTS, RxD_par, RxD_start,
                    output TX, CTS, TxD_par, TxD_ready);
endinterface

// File: rtl/uart_ip.sv
// Full-duplex 8N1 UART bridge: RX line -> TxD_par/TxD_ready, RxD_par/RxD_start -> TX line,
// with a one-byte TX holding register and active-low RTS/CTS flow control.
module uart_ip #(
    parameter int CLK_HZ = 200_000_000,
    parameter int BAUD   = 115200
) (
    input logic       sys_clk,
    input logic       sys_rst,
    uart_ip_if.slave  bus
);
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

    localparam logic [2:0] RX_IDLE  = 3'd0;
    localparam logic [2:0] RX_START = 3'd1;
    localparam logic [2:0] RX_DATA  = 3'd2;
    localparam logic [2:0] RX_STOP  = 3'd3;
    localparam logic [2:0] RX_BREAK = 3'd4;

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

    logic          rx_meta, rx_sync;
    logic [2:0]    rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic [7:0]    rx_data;
    logic          rx_ready;

    logic          rts_meta, rts_sync;
    logic [7:0]    hr;
    logic          hr_full;
    logic [1:0]    tx_state;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_shift;
    logic          tx_line;

    logic          tx_frame_end, tx_load, hr_accept;

    assign bus.TX        = tx_line;
    assign bus.CTS       = hr_full;
    assign bus.TxD_par   = rx_data;
    assign bus.TxD_ready = rx_ready;

    // A framing error parks in RX_BREAK so a held-low line cannot start a bogus frame.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            rx_ready <= 1'b0;
        end else begin
            rx_meta  <= bus.RX;
            rx_sync  <= rx_meta;
            rx_ready <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    rx_bit <= '0;
                    if (!rx_sync) rx_state <= RX_START;
                end
                RX_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                        else                rx_bit   <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt <= '0;
                        if (rx_sync) begin
                            rx_data  <= rx_shift;
                            rx_ready <= 1'b1;
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_state <= RX_BREAK;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                RX_BREAK: if (rx_sync) rx_state <= RX_IDLE;
                default:  rx_state <= RX_IDLE;
            endcase
        end
    end

    // Reloading straight from STOP keeps TX frames exactly as long as RX frames in loopback.
    assign tx_frame_end = (tx_state == TX_STOP) && (tx_cnt == BIT_LAST);
    assign tx_load      = hr_full && !rts_sync && ((tx_state == TX_IDLE) || tx_frame_end);
    assign hr_accept    = bus.RxD_start && (!hr_full || tx_load);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rts_meta <= 1'b1;
            rts_sync <= 1'b1;
            hr       <= '0;
            hr_full  <= 1'b0;
        end else begin
            rts_meta <= bus.RTS;
            rts_sync <= rts_meta;
            if (hr_accept) hr <= bus.RxD_par;
            if (hr_accept)    hr_full <= 1'b1;
            else if (tx_load) hr_full <= 1'b0;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_line  <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    tx_line <= 1'b1;
                    tx_cnt  <= '0;
                    if (tx_load) begin
                        tx_shift <= hr;
                        tx_line  <= 1'b0;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        tx_line  <= tx_shift[0];
                        tx_state <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            tx_line  <= 1'b1;
                            tx_state <= TX_STOP;
                        end else begin
                            tx_bit   <= tx_bit + 3'd1;
                            tx_shift <= {1'b0, tx_shift[7:1]};
                            tx_line  <= tx_shift[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                TX_STOP: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_load) begin
                            tx_shift <= hr;
                            tx_line  <= 1'b0;
                            tx_state <= TX_START;
                        end else begin
                            tx_state <= TX_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_ip.sv
// Directed bench for uart_ip at a scaled-down line rate (32 clocks per bit).
// A serial monitor decodes the TX line; a strobe counter tracks TxD_ready pulses.
module tb_uart_ip;
    localparam int CLK_HZ = 200_000_000;
    localparam int BAUD   = 6_250_000;
    localparam int CPB    = CLK_HZ / BAUD;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;

    uart_ip_if bus ();

    logic       loopback  = 1'b0;
    logic [7:0] drv_par   = 8'h00;
    logic       drv_start = 1'b0;

    assign bus.RxD_par   = loopback ? bus.TxD_par   : drv_par;
    assign bus.RxD_start = loopback ? bus.TxD_ready : drv_start;

    uart_ip #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus.slave)
    );

    always #5 sys_clk = ~sys_clk;

    int checks      = 0;
    int errors      = 0;
    int cycle       = 0;
    int strobes     = 0;
    int strobe_cycle = 0;
    int frame_start = 0;
    logic mon_en    = 1'b0;

    logic [7:0] tx_bytes[$];
    logic       tx_stops[$];
    int         tx_widths[$];

    always @(posedge sys_clk) cycle <= cycle + 1;

    always @(posedge sys_clk) begin
        if (bus.TxD_ready === 1'b1) begin
            strobes      <= strobes + 1;
            strobe_cycle <= cycle;
        end
    end

    // Decode each TX frame at mid-bit, also recording how many clocks the start bit lasted.
    initial begin : tx_monitor
        logic [7:0] b;
        int w;
        forever begin
            @(posedge sys_clk); #1;
            if (mon_en && bus.TX === 1'b0) begin
                w = 0;
                while (bus.TX === 1'b0 && w < 2*CPB) begin
                    w++;
                    @(posedge sys_clk); #1;
                end
                repeat (CPB/2) @(posedge sys_clk);
                #1 b[0] = bus.TX;
                for (int i = 1; i < 8; i++) begin
                    repeat (CPB) @(posedge sys_clk);
                    #1 b[i] = bus.TX;
                end
                repeat (CPB) @(posedge sys_clk);
                #1;
                tx_stops.push_back(bus.TX);
                tx_bytes.push_back(b);
                tx_widths.push_back(w);
            end
        end
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Caller must be sitting on a negedge; the line is left at the stop-bit level.
    task automatic apply_stimulus(input logic [7:0] data, input logic stop_bit);
        bus.RX = 1'b0;
        frame_start = cycle;
        repeat (CPB) @(negedge sys_clk);
        for (int i = 0; i < 8; i++) begin
            bus.RX = data[i];
            repeat (CPB) @(negedge sys_clk);
        end
        bus.RX = stop_bit;
        repeat (CPB) @(negedge sys_clk);
    endtask

    task automatic wait_tx(input int n, input int budget);
        int k = 0;
        while (tx_bytes.size() < n && k < budget) begin
            @(negedge sys_clk);
            k++;
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin : main
        int base;
        int pos;
        bus.RX  = 1'b1;
        bus.RTS = 1'b0;
        mon_en  = 1'b1;
        repeat (5) @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);

        $display("[TB] reset state");
        check_output("reset_tx",    32'(bus.TX),        32'd1);
        check_output("reset_cts",   32'(bus.CTS),       32'd0);
        check_output("reset_ready", 32'(bus.TxD_ready), 32'd0);
        check_output("reset_par",   32'(bus.TxD_par),   32'h00);
        repeat (3*CPB) @(negedge sys_clk);
        check_output("idle_no_strobe", 32'(strobes), 32'd0);

        $display("[TB] single RX frame 0x2A");
        base = strobes;
        apply_stimulus(8'h2A, 1'b1);
        repeat (8) @(negedge sys_clk);
        pos = strobe_cycle - frame_start;
        check_output("rx2a_count", 32'(strobes - base), 32'd1);
        check_output("rx2a_data",  32'(bus.TxD_par),    32'h2A);
        check_output("rx2a_midstop", 32'(pos >= 9*CPB + CPB/4 && pos < 10*CPB), 32'd1);
        check_output("rx2a_tx_quiet", 32'(bus.TX), 32'd1);
        check_output("rx2a_no_tx_frame", 32'(tx_bytes.size()), 32'd0);

        $display("[TB] loopback, three back-to-back 0xAB frames");
        loopback = 1'b1;
        base = strobes;
        for (int f = 0; f < 3; f++) apply_stimulus(8'hAB, 1'b1);
        wait_tx(3, 12*CPB);
        repeat (CPB) @(negedge sys_clk);
        check_output("loop_strobes", 32'(strobes - base),   32'd3);
        check_output("loop_frames",  32'(tx_bytes.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check_output($sformatf("loop_byte%0d", i),  32'(tx_bytes[i]),  32'hAB);
            check_output($sformatf("loop_stop%0d", i),  32'(tx_stops[i]),  32'd1);
            check_output($sformatf("loop_width%0d", i), 32'(tx_widths[i]), 32'(CPB));
        end

        $display("[TB] idle gap then one more 0xAB");
        repeat (75) @(negedge sys_clk);
        check_output("gap_cts_before", 32'(bus.CTS), 32'd0);
        base = strobes;
        apply_stimulus(8'hAB, 1'b1);
        wait_tx(4, 12*CPB);
        repeat (2*CPB) @(negedge sys_clk);
        check_output("gap_strobe", 32'(strobes - base), 32'd1);
        check_output("gap_frames", 32'(tx_bytes.size()), 32'd4);
        check_output("gap_byte",   32'(tx_bytes[3]),     32'hAB);
        check_output("gap_cts_after", 32'(bus.CTS), 32'd0);

        $display("[TB] RTS flow control");
        loopback = 1'b0;
        bus.RTS  = 1'b1;
        repeat (4) @(negedge sys_clk);
        drv_par   = 8'h55;
        drv_start = 1'b1;
        @(negedge sys_clk);
        drv_start = 1'b0;
        check_output("rts_cts_full", 32'(bus.CTS), 32'd1);
        repeat (3*CPB) @(negedge sys_clk);
        check_output("rts_tx_held", 32'(bus.TX), 32'd1);
        check_output("rts_no_frame", 32'(tx_bytes.size()), 32'd4);
        drv_par   = 8'hC3;
        drv_start = 1'b1;
        @(negedge sys_clk);
        drv_start = 1'b0;
        repeat (4) @(negedge sys_clk);
        check_output("rts_cts_still", 32'(bus.CTS), 32'd1);
        bus.RTS = 1'b0;
        repeat (6) @(negedge sys_clk);
        check_output("rts_cts_release", 32'(bus.CTS), 32'd0);
        wait_tx(5, 12*CPB);
        repeat (12*CPB) @(negedge sys_clk);
        check_output("rts_byte",   32'(tx_bytes[4]),     32'h55);
        check_output("rts_frames", 32'(tx_bytes.size()), 32'd5);

        $display("[TB] glitch, framing error, re-arm");
        base = strobes;
        bus.RX = 1'b0;
        repeat (8) @(negedge sys_clk);
        bus.RX = 1'b1;
        repeat (2*CPB) @(negedge sys_clk);
        check_output("glitch_no_strobe", 32'(strobes - base), 32'd0);
        apply_stimulus(8'h3C, 1'b0);
        bus.RX = 1'b1;
        repeat (2*CPB) @(negedge sys_clk);
        check_output("frame_err_no_strobe", 32'(strobes - base), 32'd0);
        check_output("frame_err_hold",      32'(bus.TxD_par),    32'hAB);
        apply_stimulus(8'h96, 1'b1);
        repeat (8) @(negedge sys_clk);
        check_output("rearm_strobe", 32'(strobes - base), 32'd1);
        check_output("rearm_data",   32'(bus.TxD_par),    32'h96);

        $display("[TB] reset in the middle of a TX frame");
        mon_en = 1'b0;
        base = strobes;
        drv_par   = 8'h00;
        drv_start = 1'b1;
        @(negedge sys_clk);
        drv_start = 1'b0;
        repeat (3*CPB) @(negedge sys_clk);
        check_output("midtx_busy", 32'(bus.TX), 32'd0);
        sys_rst = 1'b1;
        #1;
        check_output("midtx_rst_tx",  32'(bus.TX),  32'd1);
        check_output("midtx_rst_cts", 32'(bus.CTS), 32'd0);
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (4*CPB) @(negedge sys_clk);
        check_output("post_rst_tx_idle", 32'(bus.TX),          32'd1);
        check_output("post_rst_par",     32'(bus.TxD_par),     32'h00);
        check_output("post_rst_strobe",  32'(strobes - base),  32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
